// File: rtl/channel_voice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | channel_voice: phase-accumulated square wave, envelope-scaled, PWM output  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module channel_voice #(
   parameter int PHASE_WIDTH = 32,
   parameter int ENV_WIDTH   = 9
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_sample_stb,
   input  logic [PHASE_WIDTH-1:0] i_phase_delta,
   input  logic [7:0]             i_top,
   input  logic                   i_top_valid,
   input  logic [ENV_WIDTH-1:0]   i_envelope,
   output logic [ENV_WIDTH-1:0]   o_sample,
   output logic                   o_sample_valid,
   output logic                   o_pwm
);

   localparam logic [7:0]           c_top_reset = 8'h80;
   localparam logic [ENV_WIDTH-1:0] c_cnt_max   = ENV_WIDTH'((2 ** ENV_WIDTH) - 2);
   localparam logic [ENV_WIDTH-1:0] c_cnt_one   = ENV_WIDTH'(1);

   logic [PHASE_WIDTH-1:0] r_phase;
   logic [7:0]             r_top_pending;
   logic [7:0]             r_top_active;
   logic                   r_rest;
   logic [ENV_WIDTH-1:0]   r_env;
   logic                   r_stage1_valid;
   logic [ENV_WIDTH-1:0]   r_sample;
   logic                   r_sample_valid;
   logic [ENV_WIDTH-1:0]   r_pwm_cnt;
   logic [ENV_WIDTH-1:0]   r_pwm_level;
   logic                   r_pwm;

   logic [PHASE_WIDTH:0]   w_sum;
   logic                   w_rest;
   logic                   w_wrap;
   logic                   w_wave;
   logic [ENV_WIDTH-1:0]   w_level;
   logic                   w_cnt_end;
   logic [ENV_WIDTH-1:0]   w_cnt_next;
   logic [ENV_WIDTH-1:0]   w_level_next;

   assign w_sum   = {1'b0, r_phase} + {1'b0, i_phase_delta};
   assign w_rest  = (i_phase_delta == '0);
   assign w_wrap  = i_sample_stb & (w_rest | w_sum[PHASE_WIDTH]);

   // Evaluated from stage-1 state, so a duty loaded on a wrap edge shows in that sample
   assign w_wave  = ~r_rest & (r_phase[PHASE_WIDTH-1 -: 8] < r_top_active);
   assign w_level = w_wave ? r_env : '0;

   // Stage 1: phase, duty and envelope capture
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_phase        <= '0;
         r_top_pending  <= c_top_reset;
         r_top_active   <= c_top_reset;
         r_rest         <= 1'b0;
         r_env          <= '0;
         r_stage1_valid <= 1'b0;
      end else begin
         r_stage1_valid <= i_sample_stb;
         if (i_top_valid) begin
            r_top_pending <= i_top;
         end
         if (w_wrap) begin
            r_top_active <= i_top_valid ? i_top : r_top_pending;
         end
         if (i_sample_stb) begin
            r_phase <= w_rest ? '0 : w_sum[PHASE_WIDTH-1:0];
            r_rest  <= w_rest;
            r_env   <= i_envelope;
         end
      end
   end

   // Stage 2: registered sample
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sample       <= '0;
         r_sample_valid <= 1'b0;
      end else begin
         r_sample_valid <= r_stage1_valid;
         if (r_stage1_valid) begin
            r_sample <= w_level;
         end
      end
   end

   // PWM: level only changes at the period boundary; output is registered so it cannot glitch
   assign w_cnt_end    = (r_pwm_cnt == c_cnt_max);
   assign w_cnt_next   = w_cnt_end ? '0 : r_pwm_cnt + c_cnt_one;
   assign w_level_next = w_cnt_end ? r_sample : r_pwm_level;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pwm_cnt   <= '0;
         r_pwm_level <= '0;
         r_pwm       <= 1'b0;
      end else begin
         r_pwm_cnt   <= w_cnt_next;
         r_pwm_level <= w_level_next;
         r_pwm       <= (w_cnt_next < w_level_next);
      end
   end

   assign o_sample       = r_sample;
   assign o_sample_valid = r_sample_valid;
   assign o_pwm          = r_pwm;

endmodule
`default_nettype wire
